// File: rtl/microstep_sequencer.sv
// Per-instruction control FSM for the kpu datapath: fetch, operand read, settle, write-back.
// Sole owner of every bus driver output enable and latch write enable; at most one driver per cycle.
module microstep_sequencer #(
   parameter int WAIT_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_n_rst,
   input  logic              i_n_booted,
   input  logic              i_mem_wait,
   input  logic [1:0]        i_ctrl_src,
   input  logic              i_ctrl_use_b,
   input  logic              i_ctrl_wb,
   input  logic [WAIT_W-1:0] i_ctrl_wait,
   input  logic              i_ctrl_halt,
   output logic              o_mem_n_oe,
   output logic              o_op_n_we,
   output logic              o_tmp0_n_we,
   output logic              o_tmp1_n_we,
   output logic              o_reg_n_oe,
   output logic              o_reg_n_we,
   output logic [1:0]        o_reg_sel,
   output logic              o_mlu_n_oe,
   output logic              o_shifter_n_oe,
   output logic [2:0]        o_state,
   output logic [CNT_W-1:0]  o_retired,
   output logic              o_fault
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_RD_A   = 3'd3,
      S_RD_B   = 3'd4,
      S_EXEC   = 3'd5,
      S_WB     = 3'd6,
      S_HALTED = 3'd7
   } state_t;

   localparam logic [1:0] SRC_SHIFTER = 2'd1;
   localparam logic [1:0] SRC_MOVE    = 2'd2;
   localparam logic [1:0] SRC_INVALID = 2'd3;

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_src;
   logic                r_use_b;
   logic                r_wb;
   logic [WAIT_W-1:0]   r_wait;
   logic [WAIT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]    r_retired;
   logic                r_fault;
   logic                w_retire;
   logic                w_fault_set;

   logic                r_mem_n_oe, r_op_n_we, r_tmp0_n_we, r_tmp1_n_we;
   logic                r_reg_n_oe, r_reg_n_we, r_mlu_n_oe, r_shifter_n_oe;
   logic [1:0]          r_reg_sel;
   logic                w_mem_n_oe, w_op_n_we, w_tmp0_n_we, w_tmp1_n_we;
   logic                w_reg_n_oe, w_reg_n_we, w_mlu_n_oe, w_shifter_n_oe;
   logic [1:0]          w_reg_sel;

   always_comb begin
      w_next      = r_state;
      w_retire    = 1'b0;
      w_fault_set = 1'b0;
      case (r_state)
         S_IDLE:   if (!i_n_booted) w_next = S_FETCH;
         S_FETCH:  if (!i_mem_wait) w_next = S_DECODE;
         S_DECODE: begin
            // HALT wins the transition, but an invalid source still flags the fault
            if (i_ctrl_halt || i_ctrl_src == SRC_INVALID) begin
               w_next      = S_HALTED;
               w_fault_set = (i_ctrl_src == SRC_INVALID);
            end else begin
               w_next = S_RD_A;
            end
         end
         S_RD_A:   w_next = r_use_b ? S_RD_B : S_EXEC;
         S_RD_B:   w_next = S_EXEC;
         S_EXEC: begin
            if (r_cnt == '0) begin
               w_next   = r_wb ? S_WB : S_FETCH;
               w_retire = !r_wb;
            end
         end
         S_WB: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_HALTED: w_next = S_HALTED;
         default:  w_next = S_IDLE;
      endcase
      // Losing boot drops the in-flight instruction without retiring or faulting it
      if (i_n_booted && r_state != S_HALTED) begin
         w_next      = S_IDLE;
         w_retire    = 1'b0;
         w_fault_set = 1'b0;
      end
   end

   // Enables are decoded from the next state so the registered outputs line up with r_state
   always_comb begin
      w_mem_n_oe     = 1'b1;
      w_op_n_we      = 1'b1;
      w_tmp0_n_we    = 1'b1;
      w_tmp1_n_we    = 1'b1;
      w_reg_n_oe     = 1'b1;
      w_reg_n_we     = 1'b1;
      w_mlu_n_oe     = 1'b1;
      w_shifter_n_oe = 1'b1;
      w_reg_sel      = 2'd0;
      case (w_next)
         S_FETCH: begin
            w_mem_n_oe = 1'b0;
            w_op_n_we  = 1'b0;
         end
         S_RD_A: begin
            w_reg_n_oe  = 1'b0;
            w_tmp0_n_we = 1'b0;
         end
         S_RD_B: begin
            w_reg_sel   = 2'd1;
            w_reg_n_oe  = 1'b0;
            w_tmp1_n_we = 1'b0;
         end
         S_WB: begin
            w_reg_n_we = 1'b0;
            // A move goes through the MLU in pass-A mode so the reg file never drives while writing
            if (r_src == SRC_SHIFTER) w_shifter_n_oe = 1'b0;
            else                      w_mlu_n_oe     = 1'b0;
            w_reg_sel = (r_src == SRC_MOVE) ? 2'd0 : 2'd2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_state        <= S_IDLE;
         r_src          <= 2'd0;
         r_use_b        <= 1'b0;
         r_wb           <= 1'b0;
         r_wait         <= '0;
         r_cnt          <= '0;
         r_retired      <= '0;
         r_fault        <= 1'b0;
         r_mem_n_oe     <= 1'b1;
         r_op_n_we      <= 1'b1;
         r_tmp0_n_we    <= 1'b1;
         r_tmp1_n_we    <= 1'b1;
         r_reg_n_oe     <= 1'b1;
         r_reg_n_we     <= 1'b1;
         r_mlu_n_oe     <= 1'b1;
         r_shifter_n_oe <= 1'b1;
         r_reg_sel      <= 2'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_src   <= i_ctrl_src;
            r_use_b <= i_ctrl_use_b;
            r_wb    <= i_ctrl_wb;
            r_wait  <= i_ctrl_wait;
         end
         if (w_next == S_EXEC && r_state != S_EXEC) r_cnt <= r_wait;
         else if (r_state == S_EXEC && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         if (w_retire)    r_retired <= r_retired + 1'b1;
         if (w_fault_set) r_fault   <= 1'b1;
         r_mem_n_oe     <= w_mem_n_oe;
         r_op_n_we      <= w_op_n_we;
         r_tmp0_n_we    <= w_tmp0_n_we;
         r_tmp1_n_we    <= w_tmp1_n_we;
         r_reg_n_oe     <= w_reg_n_oe;
         r_reg_n_we     <= w_reg_n_we;
         r_mlu_n_oe     <= w_mlu_n_oe;
         r_shifter_n_oe <= w_shifter_n_oe;
         r_reg_sel      <= w_reg_sel;
      end
   end

   assign o_mem_n_oe     = r_mem_n_oe;
   assign o_op_n_we      = r_op_n_we;
   assign o_tmp0_n_we    = r_tmp0_n_we;
   assign o_tmp1_n_we    = r_tmp1_n_we;
   assign o_reg_n_oe     = r_reg_n_oe;
   assign o_reg_n_we     = r_reg_n_we;
   assign o_reg_sel      = r_reg_sel;
   assign o_mlu_n_oe     = r_mlu_n_oe;
   assign o_shifter_n_oe = r_shifter_n_oe;
   assign o_state        = r_state;
   assign o_retired      = r_retired;
   assign o_fault        = r_fault;

endmodule

// File: tb/tb_microstep_sequencer.sv
// Directed bench for microstep_sequencer: reset, full instruction, fetch stall, fault/halt,
// boot loss mid-instruction and retired-counter wrap on back-to-back short instructions.
module tb_microstep_sequencer;
   localparam int WAIT_W = 4;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              n_booted;
   logic              mem_wait;
   logic [1:0]        ctrl_src;
   logic              ctrl_use_b;
   logic              ctrl_wb;
   logic [WAIT_W-1:0] ctrl_wait;
   logic              ctrl_halt;
   logic              mem_n_oe, op_n_we, tmp0_n_we, tmp1_n_we;
   logic              reg_n_oe, reg_n_we, mlu_n_oe, shifter_n_oe;
   logic [1:0]        reg_sel;
   logic [2:0]        state;
   logic [CNT_W-1:0]  retired;
   logic              fault;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   microstep_sequencer #(.WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_n_rst(n_rst), .i_n_booted(n_booted), .i_mem_wait(mem_wait),
      .i_ctrl_src(ctrl_src), .i_ctrl_use_b(ctrl_use_b), .i_ctrl_wb(ctrl_wb),
      .i_ctrl_wait(ctrl_wait), .i_ctrl_halt(ctrl_halt),
      .o_mem_n_oe(mem_n_oe), .o_op_n_we(op_n_we), .o_tmp0_n_we(tmp0_n_we),
      .o_tmp1_n_we(tmp1_n_we), .o_reg_n_oe(reg_n_oe), .o_reg_n_we(reg_n_we),
      .o_reg_sel(reg_sel), .o_mlu_n_oe(mlu_n_oe), .o_shifter_n_oe(shifter_n_oe),
      .o_state(state), .o_retired(retired), .o_fault(fault)
   );

   // Enable vector order: {mem_oe, op_we, tmp0_we, tmp1_we, reg_oe, reg_we, mlu_oe, shf_oe}
   function automatic logic [7:0] en_vec();
      return {mem_n_oe, op_n_we, tmp0_n_we, tmp1_n_we, reg_n_oe, reg_n_we, mlu_n_oe, shifter_n_oe};
   endfunction

   function automatic int n_drivers();
      return int'(!mem_n_oe) + int'(!reg_n_oe) + int'(!mlu_n_oe) + int'(!shifter_n_oe);
   endfunction

   task automatic do_reset();
      n_rst = 1'b0; n_booted = 1'b1; mem_wait = 1'b0; ctrl_src = 2'd0; ctrl_use_b = 1'b0;
      ctrl_wb = 1'b0; ctrl_wait = '0; ctrl_halt = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (state !== 3'd0 || en_vec() !== 8'hFF || retired !== 4'd0 || fault !== 1'b0 || reg_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset cyc%0d: state=%0d en=%h ret=%0d fault=%b sel=%0d, want 0 ff 0 0 0",
                     i, state, en_vec(), retired, fault, reg_sel);
         end
      end
   endtask

   task automatic test_full_instr();
      int         exp_s[9]    = '{1, 2, 3, 4, 5, 5, 5, 6, 1};
      logic [7:0] exp_en[9]   = '{8'h3F, 8'hFF, 8'hD7, 8'hE7, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'h3F};
      int         exp_sel[9]  = '{0, 0, 0, 1, 0, 0, 0, 2, 0};
      int         exp_ret[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      do_reset();
      @(negedge clk);
      n_booted = 1'b0; ctrl_src = 2'd0; ctrl_use_b = 1'b1; ctrl_wb = 1'b1; ctrl_wait = 4'd2;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         total++;
         if (state !== 3'(exp_s[k]) || en_vec() !== exp_en[k] || reg_sel !== 2'(exp_sel[k]) ||
             retired !== 4'(exp_ret[k]) || n_drivers() > 1) begin
            bad++;
            $display("FAIL full_instr step%0d: state=%0d en=%h sel=%0d ret=%0d drv=%0d, want %0d %h %0d %0d <=1",
                     k, state, en_vec(), reg_sel, retired, n_drivers(), exp_s[k], exp_en[k], exp_sel[k], exp_ret[k]);
         end
      end
   endtask

   task automatic test_fetch_wait();
      do_reset();
      @(negedge clk);
      n_booted = 1'b0; mem_wait = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         total++;
         if (state !== 3'd1 || op_n_we !== 1'b0 || mem_n_oe !== 1'b0) begin
            bad++;
            $display("FAIL fetch_wait cyc%0d: state=%0d op_n_we=%b mem_n_oe=%b, want 1 0 0", i, state, op_n_we, mem_n_oe);
         end
         if (i == 4) mem_wait = 1'b0;
      end
      @(negedge clk);
      total++;
      if (state !== 3'd2 || en_vec() !== 8'hFF) begin
         bad++;
         $display("FAIL fetch_wait decode: state=%0d en=%h, want 2 ff", state, en_vec());
      end
   endtask

   task automatic test_fault();
      do_reset();
      @(negedge clk);
      n_booted = 1'b0; ctrl_src = 2'd3;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         total++;
         if (state !== 3'd7 || fault !== 1'b1 || en_vec() !== 8'hFF) begin
            bad++;
            $display("FAIL fault_halt cyc%0d: state=%0d fault=%b en=%h, want 7 1 ff", i, state, fault, en_vec());
         end
         if (i == 10) n_booted = 1'b1;
         @(negedge clk);
      end
      #2 n_rst = 1'b0;
      #1;
      total++;
      if (state !== 3'd0 || fault !== 1'b0 || en_vec() !== 8'hFF) begin
         bad++;
         $display("FAIL fault_async_clear: state=%0d fault=%b en=%h, want 0 0 ff", state, fault, en_vec());
      end
      @(negedge clk);
      n_rst = 1'b1;
      // HALT with a valid source stops without raising the fault
      @(negedge clk);
      n_booted = 1'b0; ctrl_src = 2'd0; ctrl_halt = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (state !== 3'd7 || fault !== 1'b0) begin
         bad++;
         $display("FAIL halt_nofault: state=%0d fault=%b, want 7 0", state, fault);
      end
   endtask

   task automatic test_boot_loss();
      do_reset();
      @(negedge clk);
      n_booted = 1'b0; ctrl_src = 2'd0; ctrl_use_b = 1'b0; ctrl_wb = 1'b1; ctrl_wait = 4'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (reg_n_we !== 1'b1) begin
            total++; bad++;
            $display("FAIL boot_loss reg_we cyc%0d: reg_n_we=%b, want 1", i, reg_n_we);
         end
      end
      total++;
      if (state !== 3'd5) begin
         bad++;
         $display("FAIL boot_loss pre: state=%0d, want 5", state);
      end
      n_booted = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (state !== 3'd0 || retired !== 4'd0 || en_vec() !== 8'hFF) begin
            bad++;
            $display("FAIL boot_loss idle cyc%0d: state=%0d ret=%0d en=%h, want 0 0 ff", i, state, retired, en_vec());
         end
      end
   endtask

   task automatic test_wb_sources();
      logic [7:0] exp_en[2]  = '{8'hFA, 8'hF9};
      int         exp_sel[2] = '{2, 0};
      for (int s = 0; s < 2; s++) begin
         do_reset();
         @(negedge clk);
         n_booted = 1'b0; ctrl_src = 2'(s + 1); ctrl_use_b = 1'b0; ctrl_wb = 1'b1; ctrl_wait = 4'd0;
         repeat (5) @(negedge clk);
         total++;
         if (state !== 3'd6 || en_vec() !== exp_en[s] || reg_sel !== 2'(exp_sel[s]) || n_drivers() != 1) begin
            bad++;
            $display("FAIL wb_src%0d: state=%0d en=%h sel=%0d drv=%0d, want 6 %h %0d 1",
                     s + 1, state, en_vec(), reg_sel, n_drivers(), exp_en[s], exp_sel[s]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int pat[4] = '{1, 2, 3, 5};
      do_reset();
      @(negedge clk);
      n_booted = 1'b0; ctrl_src = 2'd0; ctrl_use_b = 1'b0; ctrl_wb = 1'b0; ctrl_wait = 4'd0;
      for (int k = 0; k < 65; k++) begin
         @(negedge clk);
         total++;
         if (state !== 3'(pat[k % 4]) || retired !== 4'((k / 4) % 16) || n_drivers() > 1) begin
            bad++;
            $display("FAIL back_to_back obs%0d: state=%0d ret=%0d drv=%0d, want %0d %0d <=1",
                     k, state, retired, n_drivers(), pat[k % 4], (k / 4) % 16);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_instr();
      test_fetch_wait();
      test_fault();
      test_boot_loss();
      test_wb_sources();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
